// File: rtl/mul_div_ctrl.sv
// Iterative HI/LO multiply/divide unit.
// MULT/MULTU use 32 shift-add steps and DIV/DIVU use 32 restoring divide steps,
// both on operand magnitudes. A FIX cycle then applies the sign and commits HI/LO.
// MTHI/MTLO write HI/LO directly from IDLE. cancel aborts the operation in flight
// without touching HI/LO.
module mul_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 CNT_W    = 5;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Iteration state.
  // For multiply, rem holds the upper accumulator and quo the multiplier being
  // shifted out. For divide, rem holds the partial remainder and quo collects
  // quotient bits.
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic [WIDTH-1:0] quo_q,     quo_d;
  logic [WIDTH-1:0] opb_q,     opb_d;      // multiplicand or divisor magnitude
  logic             is_div_q,  is_div_d;
  logic             neg_q,     neg_d;      // negate product / quotient
  logic             rem_neg_q, rem_neg_d;  // remainder takes the dividend sign
  logic             div0_q,    div0_d;
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;
  logic             done_q,    done_d;

  // Decoded request and control enables.
  logic is_mul_op, is_div_op, signed_op;
  logic accept, load_en, mthi_en, mtlo_en, step_en, commit_en;

  // Datapath intermediates.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> CALC (32 steps) -> FIX -> IDLE, cancel exits early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_en) state_d = S_CALC;
      S_CALC: begin
        if (cancel)                 state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy flag and the per-cycle datapath enables.
  always_comb begin
    accept    = (state_q == S_IDLE) && start && !cancel;
    busy      = (state_q != S_IDLE);
    load_en   = accept && (is_mul_op || is_div_op);
    mthi_en   = accept && (op == OP_MTHI);
    mtlo_en   = accept && (op == OP_MTLO);
    step_en   = (state_q == S_CALC) && !cancel;
    commit_en = (state_q == S_FIX) && !cancel;
  end

  // Datapath next-state: operand load, one iteration step, sign fix and commit.
  always_comb begin
    // NOTE: each target takes its hold value first, so no path through the
    // enables leaves a variable unassigned and infers a latch.
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = commit_en;

    a_neg = signed_op && opA[WIDTH-1];
    b_neg = signed_op && opB[WIDTH-1];
    a_mag = a_neg ? (~opA + ONE_W) : opA;
    b_mag = b_neg ? (~opB + ONE_W) : opB;

    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    // The true remainder always fits in WIDTH bits, so modular subtraction suffices.
    div_sub   = div_shift[WIDTH-1:0] - opb_q;

    prod     = {rem_q, quo_q};
    prod_fix = neg_q ? (~prod + ONE_2W) : prod;
    quo_fix  = div0_q ? '1 : (neg_q ? (~quo_q + ONE_W) : quo_q);
    rem_fix  = rem_neg_q ? (~rem_q + ONE_W) : rem_q;

    if (mthi_en) hi_d = opA;
    if (mtlo_en) lo_d = opA;

    if (load_en) begin
      cnt_d     = '0;
      rem_d     = '0;
      is_div_d  = is_div_op;
      neg_d     = a_neg ^ b_neg;
      rem_neg_d = a_neg;
      div0_d    = (opB == '0);
      if (is_div_op) begin
        quo_d = a_mag;
        opb_d = b_mag;
      end else begin
        quo_d = b_mag;
        opb_d = a_mag;
      end
    end

    if (step_en) begin
      cnt_d = cnt_q + CNT_ONE;
      if (is_div_q) begin
        rem_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], div_ge};
      end else begin
        rem_d = mul_sum[WIDTH:1];
        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
      end
    end

    if (commit_en) begin
      if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
  end

  // Datapath and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed testbench for mul_div_ctrl. Each feature has its own task. The
// bench tracks the expected HI/LO contents in m_hi/m_lo from hand-computed
// values.
module tb_mul_div_ctrl;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .opA    (opA),
    .opB    (opB),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Issue a one-cycle request. Call at a falling edge; returns one falling edge
  // after the accepting rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
  endtask

  // Count falling edges with busy high, noting whether HI/LO left their old
  // values or done rose meanwhile. The count is bounded.
  task automatic wait_busy(output int n, output bit held);
    n = 0; held = 1'b1;
    while (busy === 1'b1 && n < 40) begin
      if (hi !== m_hi || lo !== m_lo || done !== 1'b0) held = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = OP_NOP; opA = '0; opB = '0;
    #1 reset = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int n; bit held;
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2);
    wait_busy(n, held);
    checks++; if (n !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 33", n); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hold got %b exp 1", held); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done got %b exp 1", done); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h exp fffffffe", lo); end
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFE;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", done); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_busy(n, held);
    checks++; if (n !== 33 || !held) begin errors++; $display("FAIL multu_busy got %0d/%b exp 33/1", n, held); end
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_result got %h_%h exp 00000001_fffffffe", hi, lo); end
    m_hi = 32'h1; m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_div;
    int n; bit held;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_busy(n, held);
    checks++; if (n !== 33 || !held) begin errors++; $display("FAIL div_busy got %0d/%b exp 33/1", n, held); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg7_2 got hi %h lo %h exp ffffffff fffffffd", hi, lo); end
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'h10);
    wait_busy(n, held);
    checks++; if (n !== 33 || !held) begin errors++; $display("FAIL divu_busy got %0d/%b exp 33/1", n, held); end
    checks++; if (lo !== 32'h0DEA_DBEE || hi !== 32'h0000_000F) begin errors++; $display("FAIL divu_deadbeef got hi %h lo %h exp 0000000f 0deadbee", hi, lo); end
    m_hi = 32'hF; m_lo = 32'h0DEA_DBEE;
    issue(OP_DIV, 32'h7, 32'hFFFF_FFFE);
    wait_busy(n, held);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'h1) begin errors++; $display("FAIL div_7_neg2 got hi %h lo %h exp 00000001 fffffffd", hi, lo); end
    m_hi = 32'h1; m_lo = 32'hFFFF_FFFD;
  endtask

  task automatic test_div_edge;
    int n; bit held;
    issue(OP_DIVU, 32'h1234, 32'h0);
    wait_busy(n, held);
    checks++; if (n !== 33 || !held) begin errors++; $display("FAIL divu0_busy got %0d/%b exp 33/1", n, held); end
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin errors++; $display("FAIL divu_by0 got hi %h lo %h exp 00001234 ffffffff", hi, lo); end
    m_hi = 32'h1234; m_lo = 32'hFFFF_FFFF;
    issue(OP_DIV, 32'hFFFF_FFF8, 32'h0);
    wait_busy(n, held);
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF8) begin errors++; $display("FAIL div_by0_neg got hi %h lo %h exp fffffff8 ffffffff", hi, lo); end
    m_hi = 32'hFFFF_FFF8; m_lo = 32'hFFFF_FFFF;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(n, held);
    checks++; if (n !== 33 || !held) begin errors++; $display("FAIL div_ovf_busy got %0d/%b exp 33/1", n, held); end
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin errors++; $display("FAIL div_overflow got hi %h lo %h exp 00000000 80000000", hi, lo); end
    m_hi = 32'h0; m_lo = 32'h8000_0000;
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; opA = 32'hDEAD_0000;
    @(negedge clk);
    checks++; if (hi !== 32'hDEAD_0000 || lo !== m_lo) begin errors++; $display("FAIL mthi got hi %h lo %h exp dead0000 %h", hi, lo, m_lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got busy %b done %b exp 0 0", busy, done); end
    op = OP_MTLO; opA = 32'h0000_BEEF;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    checks++; if (hi !== 32'hDEAD_0000 || lo !== 32'h0000_BEEF) begin errors++; $display("FAIL mtlo got hi %h lo %h exp dead0000 0000beef", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags got busy %b done %b exp 0 0", busy, done); end
    m_hi = 32'hDEAD_0000; m_lo = 32'h0000_BEEF;
  endtask

  task automatic test_busy_ignore;
    int n; bit held;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MULT; opA = 32'd3; opB = 32'd4;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; opA = 32'hFFFF_FFFF; opB = 32'h1;
    wait_busy(n, held);
    checks++; if (n !== 28 || !held) begin errors++; $display("FAIL ignore_busy got %0d/%b exp 28/1", n, held); end
    checks++; if (done !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL ignore_result got done %b hi %h lo %h exp 1 00000002 0000000e", done, hi, lo); end
    m_hi = 32'd2; m_lo = 32'd14;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_no_late_start got busy %b done %b exp 0 0", busy, done); end
  endtask

  task automatic test_cancel_calc;
    int n; bit held; bit saw;
    start = 1'b1; op = OP_MTHI; opA = 32'h5A5A_5A5A;
    @(negedge clk);
    op = OP_MTLO;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    m_hi = 32'h5A5A_5A5A; m_lo = 32'h5A5A_5A5A;
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel_calc_flags got busy %b done %b exp 0 0", busy, done); end
    checks++; if (hi !== 32'h5A5A_5A5A || lo !== 32'h5A5A_5A5A) begin errors++; $display("FAIL cancel_calc_hold got hi %h lo %h exp 5a5a5a5a 5a5a5a5a", hi, lo); end
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL cancel_calc_quiet got %b exp 0", saw); end
    issue(OP_MULT, 32'd3, 32'd4);
    wait_busy(n, held);
    checks++; if (n !== 33 || !held || done !== 1'b1) begin errors++; $display("FAIL after_cancel_busy got %0d/%b/%b exp 33/1/1", n, held, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0000_000C) begin errors++; $display("FAIL after_cancel_mult got hi %h lo %h exp 00000000 0000000c", hi, lo); end
    m_hi = 32'h0; m_lo = 32'hC;
  endtask

  task automatic test_cancel_fix;
    issue(OP_MULTU, 32'h10, 32'h10);
    repeat (32) @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL fix_cycle_busy got busy %b done %b exp 1 0", busy, done); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel_fix_flags got busy %b done %b exp 0 0", busy, done); end
    checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL cancel_fix_hold got hi %h lo %h exp %h %h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_cancel_start;
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = OP_MTHI; opA = 32'h1111_1111;
    @(negedge clk);
    checks++; if (hi !== m_hi) begin errors++; $display("FAIL cancel_mthi got %h exp %h", hi, m_hi); end
    op = OP_MULT; opA = 32'd3; opB = 32'd3;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_mult_start got busy %b exp 0", busy); end
    start = 1'b0; cancel = 1'b0; op = OP_NOP;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || lo !== m_lo) begin errors++; $display("FAIL cancel_start_quiet got busy %b done %b lo %h exp 0 0 %h", busy, done, lo, m_lo); end
  endtask

  task automatic test_back_to_back;
    int n; bit held;
    issue(OP_MULT, 32'd6, 32'd7);
    wait_busy(n, held);
    checks++; if (done !== 1'b1 || lo !== 32'h2A || hi !== 32'h0) begin errors++; $display("FAIL b2b_first got done %b hi %h lo %h exp 1 00000000 0000002a", done, hi, lo); end
    m_hi = 32'h0; m_lo = 32'h2A;
    issue(OP_MULTU, 32'h0001_0001, 32'h0001_0001);
    wait_busy(n, held);
    checks++; if (n !== 33 || !held) begin errors++; $display("FAIL b2b_busy got %0d/%b exp 33/1", n, held); end
    checks++; if (hi !== 32'h1 || lo !== 32'h0002_0001) begin errors++; $display("FAIL b2b_second got hi %h lo %h exp 00000001 00020001", hi, lo); end
    m_hi = 32'h1; m_lo = 32'h0002_0001;
  endtask

  task automatic test_async_reset;
    int n; bit held; bit saw;
    issue(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_flags got busy %b done %b exp 0 0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL areset_hilo got hi %h lo %h exp 0 0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) saw = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL areset_quiet got %b exp 0", saw); end
    issue(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    wait_busy(n, held);
    checks++; if (n !== 33 || lo !== 32'hFFFF_FFF2 || hi !== 32'h2) begin errors++; $display("FAIL div_100_neg7 got %0d hi %h lo %h exp 33 00000002 fffffff2", n, hi, lo); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_edge;
    test_mthi_mtlo;
    test_busy_ignore;
    test_cancel_calc;
    test_cancel_fix;
    test_cancel_start;
    test_back_to_back;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_div_ctrl.md
MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and HI/LO width; all values below assume 32.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request strobe, sampled on rising clk.
REQ-005 SHALL have port: op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
REQ-006 SHALL have port: opA  input  32  multiplicand / dividend / MTHI-MTLO source.
REQ-007 SHALL have port: opB  input  32  multiplier / divisor.
REQ-008 SHALL have port: cancel  input  1  pipeline flush; aborts the operation in flight.
REQ-009 SHALL have port: busy  output  1  high while an iterative operation occupies the unit; the pipeline stalls on MFHI/MFLO/mul/div.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, HI/LO hold the new result.
REQ-011 SHALL have ports: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; a 5-bit iteration counter is used in CALC.
REQ-013 SHALL accept start only in IDLE with cancel=0; start while busy=1 is ignored; NOP and reserved ops are ignored.
REQ-014 SHALL, on an accepted MTHI/MTLO, write opA to hi/lo at that same edge, stay IDLE, and keep busy and done at 0.
REQ-015 SHALL, on an accepted MULT/MULTU/DIV/DIVU, latch the operands and enter CALC, setting busy=1 from the next cycle.
REQ-016 SHALL, in CALC, perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle on the operand magnitudes, for exactly 32 cycles.
REQ-017 SHALL, in FIX, apply the sign correction for signed ops, write hi/lo at the FIX->IDLE edge, and then assert done for exactly one cycle.
REQ-018 SHALL give latency: start accepted at edge 0 -> busy=1 for 33 cycles -> busy=0, done=1, and new hi/lo after edge 33.
REQ-019 SHALL accept a new start in the done cycle.
REQ-020 SHALL produce, for MULT/MULTU, {hi,lo} = the 64-bit signed/unsigned product.
REQ-021 SHALL produce, for DIV/DIVU, lo = quotient truncated toward zero and hi = remainder, with the remainder sign following the dividend.
REQ-022 SHALL produce, for a divisor of 0, lo = 0xFFFFFFFF and hi = opA, with normal latency.
REQ-023 SHALL produce, for DIV 0x80000000 / 0xFFFFFFFF, lo = 0x80000000 and hi = 0.
REQ-024 SHALL keep hi/lo at their previous values while busy, so reads return the old result.
REQ-025 SHALL, on cancel=1 in CALC or FIX, enter IDLE at the next edge, leave hi/lo unchanged, give no done pulse, and set busy=0 from the next cycle.
REQ-026 SHALL, on cancel=1 together with start in IDLE, perform no operation, including MTHI/MTLO.
REQ-027 SHALL hold the operand registers unchanged outside of IDLE, so opA/opB changes during busy have no effect.

Reset
REQ-028 SHALL, on reset=1, immediately and without clk force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-029 SHALL, when reset asserts mid-operation, discard the operation with no done pulse.
REQ-030 SHALL sample the first start on the first rising clk after reset deasserts.

Verification
REQ-031 SHALL cover: MULT opA=0xFFFFFFFF, opB=2 -> busy 33 cycles, then done=1 for 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 SHALL cover: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0xDEADBEEF/0x10 -> lo=0x0DEADBEE, hi=0x0000000F.
REQ-033 SHALL cover: DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL cover: MTHI opA=0xDEAD0000, then MTLO opA=0x0000BEEF on consecutive cycles -> hi/lo update on each edge, busy stays 0; a MULT issued 5 cycles into an in-flight DIVU is ignored, and the DIVU result alone appears at cycle 33.
REQ-035 SHALL cover: a MULT 3x4 preloaded with hi=lo=0x5A5A5A5A, with cancel pulsed at CALC cycle 10 -> busy=0 next cycle, hi/lo stay 0x5A5A5A5A, no done; a following MULT 3x4 gives lo=0x0000000C.
REQ-036 SHALL cover: reset asserted mid-DIV between clock edges -> busy, done, hi, lo read 0 before the next edge, and no done pulse after release.
